uart_tx_buffered: RTL and testbench

//  Buffered UART transmitter. It is the send-side endpoint that feeds the uart_rx line.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_buffered_if.sv | 19 +
 rtl/uart_sync_fifo.sv | 46 ++++
 rtl/uart_tx_buffered.sv | 153 +++++++++++++++
 tb/tb_uart_tx_buffered.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Build option: define UART_TX_PARITY_EN to append an even-parity bit to every frame.
package uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic STOP_LEVEL = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] value);
    return ^value;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Byte-queue handshake between a producer and the buffered UART transmitter.
interface uart_tx_buffered_if #(
  parameter int FIFO_DEPTH = 8
);
  import uart_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                 start;
  logic [DATA_BITS-1:0] data;
  logic                 ready;
  logic                 busy;
  logic [CW-1:0]        count;
  logic                 overflow;

  modport master (output start, data, input ready, busy, count, overflow);
  modport slave  (input start, data, output ready, busy, count, overflow);

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO; pointers carry one extra wrap bit so full and empty differ.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO rejects the push even when a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: bytes queue in a FIFO and are sent back to back.
// Build option: UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_buffered_if.slave   bus,
  output logic                tx
);
  localparam int                BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]     BAUD_LOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

  tx_state_t            state;
  logic [BW-1:0]        baud_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] head;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 overflow;

  assign push         = bus.start && bus.ready;
  assign bus.ready    = !full;
  assign bus.busy     = (state != IDLE) || !empty;
  assign bus.overflow = overflow;

  // Pop whenever the line is free to start a new frame: from IDLE, or right at the end of STOP.
  always_comb begin
    pop = 1'b0;
    if (!empty && (state == IDLE || (state == STOP && baud_cnt == '0))) pop = 1'b1;
  end

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (bus.data),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (bus.count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overflow <= 1'b0;
    else if (bus.start && !bus.ready) overflow <= 1'b1;
  end

`ifdef UART_TX_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) par_bit <= 1'b0;
    else if (pop) par_bit <= even_parity(head);
  end
`endif

  // tx is registered: each branch sets the level of the bit being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= IDLE_LEVEL;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            shreg    <= head;
            baud_cnt <= BAUD_LOAD;
            state    <= START;
            tx       <= 1'b0;
          end else begin
            tx <= IDLE_LEVEL;
          end
        end
        START: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BAUD_LOAD;
            bit_cnt  <= '0;
            state    <= DATA;
            tx       <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BAUD_LOAD;
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= par_bit;
`else
              state <= STOP;
              tx    <= STOP_LEVEL;
`endif
            end else begin
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_cnt == '0) begin
            baud_cnt <= BAUD_LOAD;
            state    <= STOP;
            tx       <= STOP_LEVEL;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_cnt == '0) begin
            if (!empty) begin
              shreg    <= head;
              baud_cnt <= BAUD_LOAD;
              state    <= START;
              tx       <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= IDLE_LEVEL;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered; a line monitor decodes tx frames into queues.
// Honours UART_TX_PARITY_EN for frame length and the parity-bit checks.
module tb_uart_tx_buffered;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic clk;
  logic rst;
  logic tx;
  int   checks;
  int   errors;
  int   cyc;
  bit   aborted;

  logic [7:0] rx_q    [$];
  logic       stop_q  [$];
  logic       par_q   [$];
  int         start_q [$];

  uart_tx_buffered_if #(.FIFO_DEPTH(8)) bus ();

  uart_tx_buffered #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .tx  (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    aborted = 1'b0;
    forever begin
      @(negedge rst);
      aborted = 1'b1;
    end
  end

  // Samples each bit in its middle; a frame interrupted by reset is thrown away.
  initial begin
    logic [7:0] b;
    logic       st;
    logic       sp;
    logic       p;
    int         fstart;
    p = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx === 1'b0) begin
        aborted = 1'b0;
        fstart  = cyc;
        repeat (2) @(negedge clk);
        st = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        p = tx;
`endif
        repeat (CPB) @(negedge clk);
        sp = tx;
        @(negedge clk);
        if (!aborted) begin
          rx_q.push_back(b);
          stop_q.push_back(st === 1'b0 && sp === 1'b1);
          par_q.push_back(p);
          start_q.push_back(fstart);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic s, input logic [7:0] d);
    bus.start = s;
    bus.data  = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_idle(input int budget, output int waited);
    waited = 0;
    while (bus.busy !== 1'b0 && waited < budget) begin
      tick();
      waited++;
    end
    checkOutput("idle_reached", 32'(bus.busy), 32'd0);
  endtask

  task automatic clear_queues();
    rx_q.delete();
    stop_q.delete();
    par_q.delete();
    start_q.delete();
  endtask

  initial begin
    int w;
    int lows;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00);

    // Reset values
    repeat (2) tick();
    checkOutput("rst_tx", 32'(tx), 32'd1);
    checkOutput("rst_ready", 32'(bus.ready), 32'd1);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_count", 32'(bus.count), 32'd0);
    checkOutput("rst_overflow", 32'(bus.overflow), 32'd0);
    rst = 1'b1;
    tick();

    // Single byte 0x41
    $display("[TB] single frame 0x41");
    applyStimulus(1'b1, 8'h41);
    tick();
    checkOutput("t1_count_after_push", 32'(bus.count), 32'd1);
    checkOutput("t1_tx_still_idle", 32'(tx), 32'd1);
    checkOutput("t1_busy", 32'(bus.busy), 32'd1);
    applyStimulus(1'b0, 8'h00);
    tick();
    checkOutput("t1_latency_tx_low", 32'(tx), 32'd0);
    checkOutput("t1_count_after_pop", 32'(bus.count), 32'd0);
    wait_idle(200, w);
    checkOutput("t1_frame_cycles", 32'(w), 32'(FRAME));
    checkOutput("t1_frames", 32'(rx_q.size()), 32'd1);
    checkOutput("t1_byte", 32'(rx_q[0]), 32'h41);
    checkOutput("t1_framing", 32'(stop_q[0]), 32'd1);
    checkOutput("t1_overflow", 32'(bus.overflow), 32'd0);
    clear_queues();

    // Back-to-back bytes on consecutive cycles
    $display("[TB] back-to-back 0x41 0x42 0x43");
    tick();
    applyStimulus(1'b1, 8'h41);
    tick();
    checkOutput("t2_count1", 32'(bus.count), 32'd1);
    applyStimulus(1'b1, 8'h42);
    tick();
    checkOutput("t2_count_pushpop", 32'(bus.count), 32'd1);
    checkOutput("t2_tx_start", 32'(tx), 32'd0);
    checkOutput("t2_ready_a", 32'(bus.ready), 32'd1);
    applyStimulus(1'b1, 8'h43);
    tick();
    checkOutput("t2_count_peak", 32'(bus.count), 32'd2);
    checkOutput("t2_ready_b", 32'(bus.ready), 32'd1);
    applyStimulus(1'b0, 8'h00);
    wait_idle(400, w);
    checkOutput("t2_total_cycles", 32'(w + 1), 32'(3 * FRAME));
    checkOutput("t2_frames", 32'(rx_q.size()), 32'd3);
    checkOutput("t2_byte0", 32'(rx_q[0]), 32'h41);
    checkOutput("t2_byte1", 32'(rx_q[1]), 32'h42);
    checkOutput("t2_byte2", 32'(rx_q[2]), 32'h43);
    checkOutput("t2_gap01", 32'(start_q[1] - start_q[0]), 32'(FRAME));
    checkOutput("t2_gap12", 32'(start_q[2] - start_q[1]), 32'(FRAME));
    clear_queues();

    // Fill the FIFO while the first frame is on the line, then overflow it
    $display("[TB] fill and overflow");
    tick();
    applyStimulus(1'b1, 8'h10);
    for (int i = 1; i < 10; i++) begin
      tick();
      applyStimulus(1'b1, 8'(8'h10 + i));
    end
    checkOutput("t3_count_full", 32'(bus.count), 32'd8);
    checkOutput("t3_ready_full", 32'(bus.ready), 32'd0);
    checkOutput("t3_overflow_before", 32'(bus.overflow), 32'd0);
    tick();
    checkOutput("t3_overflow_set", 32'(bus.overflow), 32'd1);
    checkOutput("t3_count_unchanged", 32'(bus.count), 32'd8);
    applyStimulus(1'b0, 8'h00);
    wait_idle(600, w);
    checkOutput("t3_frames", 32'(rx_q.size()), 32'd9);
    for (int i = 0; i < 9; i++) checkOutput($sformatf("t3_byte%0d", i), 32'(rx_q[i]), 32'(8'h10 + i));
    checkOutput("t3_ready_after", 32'(bus.ready), 32'd1);
    checkOutput("t3_overflow_sticky", 32'(bus.overflow), 32'd1);
    clear_queues();

    // Asynchronous reset in the middle of the data bits of 0xA5
    $display("[TB] reset mid-frame");
    tick();
    applyStimulus(1'b1, 8'hA5);
    tick();
    applyStimulus(1'b0, 8'h00);
    tick();
    repeat (10) tick();
    checkOutput("t4_tx_bit1_low", 32'(tx), 32'd0);
    #2 rst = 1'b0;
    #1;
    checkOutput("t4_async_tx", 32'(tx), 32'd1);
    checkOutput("t4_async_count", 32'(bus.count), 32'd0);
    checkOutput("t4_async_overflow", 32'(bus.overflow), 32'd0);
    checkOutput("t4_async_busy", 32'(bus.busy), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx !== 1'b1) lows++;
    end
    checkOutput("t4_no_resume", 32'(lows), 32'd0);
    checkOutput("t4_no_frames", 32'(rx_q.size()), 32'd0);
    checkOutput("t4_busy_after", 32'(bus.busy), 32'd0);
    clear_queues();

    // Push coinciding with the STOP-to-START pop
    $display("[TB] push at frame boundary");
    tick();
    applyStimulus(1'b1, 8'h11);
    tick();
    applyStimulus(1'b0, 8'h00);
    tick();
    applyStimulus(1'b1, 8'h22);
    tick();
    checkOutput("t6_count_queued", 32'(bus.count), 32'd1);
    applyStimulus(1'b0, 8'h00);
    repeat (38) tick();
    checkOutput("t6_count_pre_boundary", 32'(bus.count), 32'd1);
    checkOutput("t6_stop_level", 32'(tx), 32'd1);
    applyStimulus(1'b1, 8'h33);
    tick();
    checkOutput("t6_count_pushpop", 32'(bus.count), 32'd1);
    checkOutput("t6_no_gap", 32'(tx), 32'd0);
    applyStimulus(1'b0, 8'h00);
    wait_idle(400, w);
    checkOutput("t6_frames", 32'(rx_q.size()), 32'd3);
    checkOutput("t6_byte0", 32'(rx_q[0]), 32'h11);
    checkOutput("t6_byte1", 32'(rx_q[1]), 32'h22);
    checkOutput("t6_byte2", 32'(rx_q[2]), 32'h33);
    checkOutput("t6_gap12", 32'(start_q[2] - start_q[1]), 32'(FRAME));
    clear_queues();

`ifdef UART_TX_PARITY_EN
    // Even parity: 0x07 has three ones, 0x03 has two
    $display("[TB] parity frames");
    tick();
    applyStimulus(1'b1, 8'h07);
    tick();
    applyStimulus(1'b0, 8'h00);
    tick();
    wait_idle(200, w);
    checkOutput("t5_frame_cycles", 32'(w), 32'd44);
    checkOutput("t5_byte07", 32'(rx_q[0]), 32'h07);
    checkOutput("t5_parity07", 32'(par_q[0]), 32'd1);
    tick();
    applyStimulus(1'b1, 8'h03);
    tick();
    applyStimulus(1'b0, 8'h00);
    wait_idle(200, w);
    checkOutput("t5_byte03", 32'(rx_q[1]), 32'h03);
    checkOutput("t5_parity03", 32'(par_q[1]), 32'd0);
    checkOutput("t5_framing", 32'(stop_q[1]), 32'd1);
    clear_queues();
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
